// File: rtl/crc16_arb_pkg.sv
// Shared types and CRC-16 constants for the frame arbiter
// and the receive-side checker.
package crc16_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC_HI,
    CRC_LO
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

endpackage

// File: rtl/crc16_byte_step.sv
// One-byte CRC-16 update, MSB first, no reflection.
// Pure combinational; shared with the receive checker.
module crc16_byte_step
  import crc16_arb_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  logic [15:0] c;

  // Fold the byte into the top of the register, then shift 8 times
  always_comb begin
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else       c = {c[14:0], 1'b0};
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc16_frame_arbiter.sv
// Round-robin per-frame arbiter that appends CRC-16 (MSB first).
// Optional payload length counter: define CRC16_ARB_LEN_EN.
module crc16_frame_arbiter
  import crc16_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [8*NUM_REQ-1:0] in_data,
  input  logic [NUM_REQ-1:0]   in_last,
  output logic [NUM_REQ-1:0]   in_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [SRC_W-1:0]     out_src,
  output logic                 busy
`ifdef CRC16_ARB_LEN_EN
  ,
  output logic [15:0]          frame_len
`endif
);

  state_t           state;
  logic [15:0]      crc;
  logic [15:0]      crc_nxt;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] win;
  logic             win_ok;
  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;
  logic             fire;

  function automatic int rr_idx(
    input logic [SRC_W-1:0] p,
    input int               off
  );
    int k;
    k = int'(p) + 1 + off;
    if (k >= NUM_REQ) k = k - NUM_REQ;
    return k;
  endfunction

  // Round-robin search starting just after the last served requester
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_ok && in_valid[j] && rr_idx(ptr, i) == j) begin
          win    = SRC_W'(j);
          win_ok = 1'b1;
        end
      end
    end
  end

  // Select the granted requester's byte lane
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant == SRC_W'(j)) begin
        g_valid = in_valid[j];
        g_last  = in_last[j];
        g_data  = in_data[8*j +: 8];
      end
    end
  end

  // Only the granted requester sees ready, and only while in DATA
  always_comb begin
    in_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (state == DATA && grant == SRC_W'(j)) in_ready[j] = out_ready;
    end
  end

  assign fire = (state == DATA) && g_valid && out_ready;
  assign busy = (state != IDLE);

  crc16_byte_step u_step (
    .crc      (crc),
    .data     (g_data),
    .crc_next (crc_nxt)
  );

  // Output stream mux: payload pass-through, then the two CRC bytes
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    unique case (1'b1)
      (state == IDLE): ;
      (state == DATA): begin
        out_valid = g_valid;
        out_data  = g_data;
      end
      (state == CRC_HI): begin
        out_valid = 1'b1;
        out_data  = crc[15:8];
      end
      (state == CRC_LO): begin
        out_valid = 1'b1;
        out_data  = crc[7:0];
        out_last  = 1'b1;
      end
    endcase
  end

  // Frame sequencer: arbitrate, accumulate CRC, emit CRC, rotate ptr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      crc     <= CRC16_INIT;
      ptr     <= SRC_W'(NUM_REQ - 1);
      grant   <= '0;
      out_src <= '0;
    end else begin
      case (state)
        IDLE: begin
          crc <= CRC16_INIT;
          if (win_ok) begin
            grant   <= win;
            out_src <= win;
            state   <= DATA;
          end
        end
        DATA: begin
          if (fire) begin
            crc <= crc_nxt;
            if (g_last) state <= CRC_HI;
          end
        end
        CRC_HI: begin
          if (out_ready) state <= CRC_LO;
        end
        CRC_LO: begin
          if (out_ready) begin
            ptr   <= grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRC16_ARB_LEN_EN
  logic [15:0] len;

  // Saturating payload byte count, held through the CRC beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len <= '0;
    end else if (state == IDLE) begin
      len <= '0;
    end else if (fire && len != 16'hFFFF) begin
      len <= len + 16'd1;
    end
  end

  assign frame_len = len;
`endif

endmodule

// File: tb/tb_crc16_frame_arbiter.sv
// Directed bench for crc16_frame_arbiter (NUM_REQ=2).
// Define CRC16_ARB_LEN_EN to also cover frame_len.
module tb_crc16_frame_arbiter;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_valid;
  logic [8*N-1:0] in_data;
  logic [N-1:0] in_last;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         out_ready;
  logic [0:0]   out_src;
  logic         busy;
`ifdef CRC16_ARB_LEN_EN
  logic [15:0]  frame_len;
`endif

  always #5 clk = ~clk;

  crc16_frame_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_src   (out_src),
    .busy      (busy)
`ifdef CRC16_ARB_LEN_EN
    ,
    .frame_len (frame_len)
`endif
  );

  int nrun = 0;
  int nfail = 0;
  int cyc;
  bit rnd_rdy = 1'b0;
  bit hold_v = 1'b0;
  logic [8:0] hold_val;
  int npay_chk = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] ob_d[$];
  logic       ob_l[$];
  logic       ob_s[$];
  int         ob_c[$];
  logic [7:0] ex_d[$];
  logic       ex_l[$];
  logic       ex_s[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nrun++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(logic [7:0] b[$]);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[i][k];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  task automatic load(int r, logic [7:0] b[$]);
    foreach (b[i]) begin
      logic [8:0] e;
      e = {(i == b.size() - 1), b[i]};
      if (r == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic exp_frame(int r, logic [7:0] b[$], logic [15:0] c);
    foreach (b[i]) begin
      ex_d.push_back(b[i]);
      ex_l.push_back(1'b0);
      ex_s.push_back(r[0]);
    end
    ex_d.push_back(c[15:8]); ex_l.push_back(1'b0); ex_s.push_back(r[0]);
    ex_d.push_back(c[7:0]);  ex_l.push_back(1'b1); ex_s.push_back(r[0]);
  endtask

  task automatic drive();
    in_valid = {q1.size() > 0, q0.size() > 0};
    in_data  = {q1.size() > 0 ? q1[0][7:0] : 8'h00,
                q0.size() > 0 ? q0[0][7:0] : 8'h00};
    in_last  = {q1.size() > 0 ? q1[0][8] : 1'b0,
                q0.size() > 0 ? q0[0][8] : 1'b0};
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic step();
    logic f0, f1;
    @(negedge clk);
    f0 = in_valid[0] & in_ready[0];
    f1 = in_valid[1] & in_ready[1];
    check("ready_onehot", $countones(in_ready) > 1, 0);
    if (hold_v) check("hold_stable", {out_last, out_data}, hold_val);
    hold_v = out_valid & !out_ready;
    hold_val = {out_last, out_data};
`ifdef CRC16_ARB_LEN_EN
    if (npay_chk > 0 && out_valid && ob_d.size() >= npay_chk)
      check("frame_len", frame_len, npay_chk);
`endif
    if (out_valid && out_ready) begin
      ob_d.push_back(out_data);
      ob_l.push_back(out_last);
      ob_s.push_back(out_src[0]);
      ob_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (f0) void'(q0.pop_front());
    if (f1) void'(q1.pop_front());
    cyc++;
    drive();
  endtask

  task automatic run(int maxc);
    int k;
    k = 0;
    cyc = 0;
    drive();
    while (!(q0.size() == 0 && q1.size() == 0 &&
             ob_d.size() >= ex_d.size() && !busy) && k < maxc) begin
      step();
      k++;
    end
    check("timeout", k < maxc, 1);
  endtask

  task automatic compare(string tag);
    check({tag, "_count"}, ob_d.size(), ex_d.size());
    for (int i = 0; i < ex_d.size() && i < ob_d.size(); i++) begin
      check($sformatf("%s_data[%0d]", tag, i), ob_d[i], ex_d[i]);
      check($sformatf("%s_last[%0d]", tag, i), ob_l[i], ex_l[i]);
      check($sformatf("%s_src[%0d]", tag, i), ob_s[i], ex_s[i]);
    end
  endtask

  task automatic clear();
    ob_d.delete(); ob_l.delete(); ob_s.delete(); ob_c.delete();
    ex_d.delete(); ex_l.delete(); ex_s.delete();
    hold_v = 1'b0;
  endtask

  initial begin
    logic [7:0] s9[$];
    logic [7:0] b[$];

    for (int i = 0; i < 9; i++) s9.push_back(8'h31 + 8'(i));

    // reset values
    rst = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_src", out_src, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // "123456789" from requester 0, 12 cycles
    load(0, s9);
    exp_frame(0, s9, 16'hFEE8);
    run(100);
    compare("check123");
    if (ob_c.size() == 11) check("frame_cycles", ob_c[10] + 1, 12);
    else check("frame_cycles_n", ob_c.size(), 11);
    clear();

    // single byte frames from requester 1
    b = '{8'h01};
    load(1, b);
    exp_frame(1, b, 16'h8005);
    run(50);
    compare("one01");
    clear();
    b = '{8'h00};
    load(1, b);
    exp_frame(1, b, 16'h0000);
    run(50);
    compare("one00");
    clear();

    // both requesters busy: grants alternate 0,1,0,1
    b = '{8'hA0, 8'hA1}; load(0, b); exp_frame(0, b, crc_model(b));
    b = '{8'hB0, 8'hB1}; load(1, b); exp_frame(1, b, crc_model(b));
    b = '{8'hA2, 8'hA3}; load(0, b); exp_frame(0, b, crc_model(b));
    b = '{8'hB2, 8'hB3}; load(1, b); exp_frame(1, b, crc_model(b));
    run(200);
    compare("rr");
    if (ob_c.size() == 16) begin
      check("rr_gap0", ob_c[4] - ob_c[3], 2);
      check("rr_gap1", ob_c[8] - ob_c[7], 2);
      check("rr_gap2", ob_c[12] - ob_c[11], 2);
    end else begin
      check("rr_gap_n", ob_c.size(), 16);
    end
    clear();

    // random backpressure, same result as the unstalled run
    rnd_rdy = 1'b1;
    load(0, s9);
    exp_frame(0, s9, 16'hFEE8);
    run(500);
    compare("stall");
    rnd_rdy = 1'b0;
    clear();

    // reset during the 3rd payload byte of a requester 1 frame
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load(1, b);
    begin
      int k;
      k = 0;
      cyc = 0;
      drive();
      while (ob_d.size() < 2 && k < 50) begin
        step();
        k++;
      end
      check("abort_reach", k < 50, 1);
    end
    #1 rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_last", out_last, 0);
    check("abort_out_src", out_src, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    q0.delete();
    q1.delete();
    clear();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    b = '{8'h01};
    load(0, b); exp_frame(0, b, 16'h8005);
    load(1, b); exp_frame(1, b, 16'h8005);
    run(100);
    compare("after_rst");
    clear();

`ifdef CRC16_ARB_LEN_EN
    // 300-byte frame, frame_len checked through both CRC beats
    b.delete();
    for (int i = 0; i < 300; i++) b.push_back(8'(i * 7 + 3));
    load(0, b);
    exp_frame(0, b, crc_model(b));
    npay_chk = 300;
    run(1000);
    npay_chk = 0;
    compare("len300");
    clear();
`endif

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
